// File: rtl/charlie_scroller.sv
// charlie_scroller: scrolls 5-row column bitmaps through a 7-column window and
// writes the window row by row to a Wishbone display peripheral on each scroll tick.
module charlie_scroller #(
  parameter int unsigned CLK_HZ     = 12000000,
  parameter int unsigned SCROLL_HZ  = 8,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [4:0] col_data,
  input  logic       col_valid,
  output logic       col_ready,
  output logic       wb_stb,
  output logic       wb_we,
  output logic [2:0] wb_adr,
  output logic [7:0] wb_dat_c,
  input  logic       wb_ack,
  output logic       underflow,
  output logic       tick_drop
);

  localparam int unsigned DIV_N   = CLK_HZ / SCROLL_HZ;
  localparam int unsigned DIV_W   = $clog2(DIV_N);
  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned COLS    = 7;
  localparam int unsigned LAST_ROW = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_WRITE,
    S_GAP
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DIV_W-1:0]  r_div;
  logic              w_tick;
  logic              w_tick_en;
  logic [4:0]        r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  w_count_nxt;
  logic              r_col_ready;
  logic              w_fifo_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_shift;
  logic [4:0]        r_win [COLS];
  logic [2:0]        r_row;
  logic              r_stb;
  logic              r_pending;
  logic              r_underflow;
  logic              r_tick_drop;
  logic [7:0]        w_dat;

  assign w_tick       = (r_div == DIV_W'(DIV_N - 1));
  assign w_tick_en    = w_tick & en;
  assign w_fifo_empty = (r_count == '0);
  assign w_shift      = (r_state == S_SHIFT);
  assign w_push       = col_valid & r_col_ready;
  assign w_pop        = w_shift & ~w_fifo_empty;

  assign col_ready = r_col_ready;
  assign wb_stb    = r_stb;
  assign wb_we     = r_stb;
  assign wb_adr    = r_row;
  assign underflow = r_underflow;
  assign tick_drop = r_tick_drop;

  // Free-running scroll divider; runs independently of en.
  always_ff @(posedge clk) begin
    if (rst || w_tick) r_div <= '0;
    else               r_div <= r_div + DIV_W'(1);
  end

  // Next FIFO occupancy from the push/pop pair.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // FIFO storage; contents need no reset since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= col_data;
  end

  // FIFO pointers, occupancy and registered not-full flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_col_ready <= 1'b1;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      r_count     <= w_count_nxt;
      r_col_ready <= (w_count_nxt != CNT_W'(FIFO_DEPTH));
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_tick_en || r_pending) w_state_nxt = S_SHIFT;
      S_SHIFT: w_state_nxt = S_WRITE;
      S_WRITE: if (wb_ack) w_state_nxt = S_GAP;
      S_GAP:   w_state_nxt = (r_row == 3'(LAST_ROW)) ? S_IDLE : S_WRITE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Row index, strobe, and pending/sticky tick bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_row       <= '0;
      r_stb       <= 1'b0;
      r_pending   <= 1'b0;
      r_tick_drop <= 1'b0;
    end else begin
      r_stb <= (w_state_nxt == S_WRITE);
      if (r_state == S_SHIFT) begin
        r_row <= '0;
      end else if (r_state == S_GAP) begin
        r_row <= (r_row == 3'(LAST_ROW)) ? 3'd0 : r_row + 3'd1;
      end
      // In IDLE a pending request is consumed; a coincident tick re-arms it.
      if (r_state == S_IDLE) begin
        r_pending <= r_pending & w_tick_en;
      end else if (w_tick_en) begin
        if (r_pending) r_tick_drop <= 1'b1;
        else           r_pending   <= 1'b1;
      end
    end
  end

  // Column window shift; blank column and sticky flag on empty FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < COLS; c++) r_win[c] <= '0;
      r_underflow <= 1'b0;
    end else if (w_shift) begin
      for (int c = 0; c < COLS - 1; c++) r_win[c] <= r_win[c+1];
      if (w_fifo_empty) begin
        r_win[COLS-1] <= '0;
        r_underflow   <= 1'b1;
      end else begin
        r_win[COLS-1] <= r_mem[r_rptr];
      end
    end
  end

  // Row pixel byte: bit c is column c at the current row; zero when idle.
  always_comb begin
    w_dat = '0;
    for (int c = 0; c < COLS; c++) w_dat[c] = r_win[c][r_row];
    wb_dat_c = r_stb ? w_dat : 8'h00;
  end

endmodule

// File: tb/tb_charlie_scroller.sv
// Scoreboard bench for charlie_scroller: a column-window model pushes expected
// row writes on each tick; the bus monitor pops and compares on every ack.
module tb_charlie_scroller;

  localparam int unsigned N = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [4:0] col_data;
  logic       col_valid;
  logic       col_ready;
  logic       wb_stb;
  logic       wb_we;
  logic [2:0] wb_adr;
  logic [7:0] wb_dat_c;
  logic       wb_ack = 1'b0;
  logic       underflow;
  logic       tick_drop;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int tb_div = 0;
  int ack_delay = 1;
  int ack_cnt = 0;
  int last_ack_cyc = 0;

  logic [10:0] exp_q [$];
  logic [4:0]  m_fifo [$];
  logic [4:0]  m_win [7];
  logic        m_under;

  logic       stb_prev = 1'b0;
  logic       ack_prev = 1'b0;
  logic [2:0] adr_prev = '0;
  logic [7:0] dat_prev = '0;

  always #5 clk = ~clk;

  charlie_scroller #(.CLK_HZ(32), .SCROLL_HZ(1), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .en(en),
    .col_data(col_data), .col_valid(col_valid), .col_ready(col_ready),
    .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr), .wb_dat_c(wb_dat_c),
    .wb_ack(wb_ack), .underflow(underflow), .tick_drop(tick_drop)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Cycle counter and reference divider phase.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst || tb_div == N - 1) tb_div <= 0;
    else                        tb_div <= tb_div + 1;
  end

  // Peripheral: registered ack after ack_delay cycles of strobe.
  always @(posedge clk) begin
    if (wb_stb !== 1'b1 || wb_ack) begin
      wb_ack  <= 1'b0;
      ack_cnt <= 0;
    end else if (ack_cnt == ack_delay - 1) begin
      wb_ack <= 1'b1;
    end else begin
      ack_cnt <= ack_cnt + 1;
    end
  end

  // Bus monitor: hold stability while waiting, compare on ack.
  always @(negedge clk) begin
    logic [10:0] e;
    if (rst === 1'b0 && wb_stb === 1'b1) begin
      if (stb_prev && !ack_prev) begin
        check_eq("hold_adr", 32'(wb_adr), 32'(adr_prev));
        check_eq("hold_dat", 32'(wb_dat_c), 32'(dat_prev));
      end
      check_eq("wb_we", 32'(wb_we), 32'd1);
      if (wb_ack) begin
        check_eq("expected_write", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_eq("wb_adr", 32'(wb_adr), 32'(e[10:8]));
          check_eq("wb_dat", 32'(wb_dat_c), 32'(e[7:0]));
        end
        last_ack_cyc = cyc;
      end
    end
    stb_prev = (wb_stb === 1'b1);
    ack_prev = wb_ack;
    adr_prev = wb_adr;
    dat_prev = wb_dat_c;
  end

  function automatic void model_reset();
    exp_q.delete();
    m_fifo.delete();
    for (int c = 0; c < 7; c++) m_win[c] = '0;
    m_under = 1'b0;
  endfunction

  // Window model: one shift, then queue the five row writes it implies.
  function automatic void model_shift();
    logic [7:0] d;
    for (int c = 0; c < 6; c++) m_win[c] = m_win[c+1];
    if (m_fifo.size() > 0) m_win[6] = m_fifo.pop_front();
    else begin
      m_win[6] = '0;
      m_under  = 1'b1;
    end
    for (int r = 0; r < 5; r++) begin
      d = 8'h00;
      for (int c = 0; c < 7; c++) d[c] = m_win[c][r];
      exp_q.push_back({3'(r), d});
    end
  endfunction

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; col_valid = 1'b0; col_data = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic push_col(input logic [4:0] v);
    int k = 0;
    col_data = v; col_valid = 1'b1;
    while (!col_ready && k < 100) begin @(negedge clk); k++; end
    check_eq("push_ready", 32'(col_ready), 32'd1);
    m_fifo.push_back(v);
    @(negedge clk);
    col_valid = 1'b0;
  endtask

  // Raise en for exactly the divider wrap cycle; returns that cycle number.
  task automatic fire_tick(output int tick_cyc);
    int k = 0;
    while (tb_div != N - 1 && k < 2 * N) begin @(negedge clk); k++; end
    en = 1'b1;
    tick_cyc = cyc;
    model_shift();
    @(negedge clk);
    en = 1'b0;
  endtask

  task automatic wait_drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 2000) begin @(negedge clk); k++; end
    check_eq("drain", 32'(exp_q.size()), 32'd0);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int tc;
    int k;
    int extra;

    // Reset state.
    do_reset();
    check_eq("rst_stb", 32'(wb_stb), 32'd0);
    check_eq("rst_we", 32'(wb_we), 32'd0);
    check_eq("rst_adr", 32'(wb_adr), 32'd0);
    check_eq("rst_dat", 32'(wb_dat_c), 32'd0);
    check_eq("rst_ready", 32'(col_ready), 32'd1);
    check_eq("rst_underflow", 32'(underflow), 32'd0);
    check_eq("rst_tick_drop", 32'(tick_drop), 32'd0);

    // Single full column: every row shows column 6 lit; 16-cycle transfer.
    push_col(5'h1F);
    fire_tick(tc);
    wait_drain();
    check_eq("xfer_last_ack", 32'(last_ack_cyc - tc), 32'd15);
    check_eq("underflow_t1", 32'(underflow), 32'd0);

    // Two columns scrolled in over two ticks.
    do_reset();
    push_col(5'h01);
    push_col(5'h02);
    fire_tick(tc);
    wait_drain();
    fire_tick(tc);
    wait_drain();
    check_eq("underflow_t2", 32'(underflow), 32'd0);

    // Empty FIFO inserts a blank column.
    do_reset();
    fire_tick(tc);
    wait_drain();
    check_eq("underflow_t3", 32'(underflow), 32'(m_under));

    // FIFO full back-pressure; ninth column waits for a pop.
    do_reset();
    col_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      col_data = 5'(i * 3 + 1);
      check_eq("ready_fill", 32'(col_ready), 32'd1);
      m_fifo.push_back(col_data);
      @(negedge clk);
    end
    col_data = 5'h1E;
    check_eq("ready_full", 32'(col_ready), 32'd0);
    repeat (3) @(negedge clk);
    check_eq("ready_held", 32'(col_ready), 32'd0);
    fire_tick(tc);
    check_eq("ready_in_shift", 32'(col_ready), 32'd0);
    @(negedge clk);
    check_eq("ready_after_pop", 32'(col_ready), 32'd1);
    m_fifo.push_back(col_data);
    @(negedge clk);
    col_valid = 1'b0;
    check_eq("ready_full_again", 32'(col_ready), 32'd0);
    wait_drain();
    for (int i = 0; i < 8; i++) begin
      fire_tick(tc);
      wait_drain();
    end
    check_eq("underflow_drained", 32'(underflow), 32'd0);
    fire_tick(tc);
    wait_drain();
    check_eq("underflow_after", 32'(underflow), 32'd1);

    // Extra ticks during a slow transfer: one pending, the rest dropped.
    do_reset();
    ack_delay = 20;
    push_col(5'h15);
    k = 0;
    while (tb_div != N - 1 && k < 2 * N) begin @(negedge clk); k++; end
    en = 1'b1;
    model_shift();
    repeat (97) @(negedge clk);
    en = 1'b0;
    model_shift();
    wait_drain();
    check_eq("tick_drop", 32'(tick_drop), 32'd1);
    check_eq("underflow_t5", 32'(underflow), 32'(m_under));
    extra = 0;
    repeat (200) begin
      @(negedge clk);
      if (wb_stb) extra++;
    end
    check_eq("no_extra_seq", 32'(extra), 32'd0);
    ack_delay = 1;

    // Reset while row 2 is on the bus.
    do_reset();
    push_col(5'h0A);
    push_col(5'h05);
    push_col(5'h11);
    fire_tick(tc);
    k = 0;
    while (!(wb_stb && wb_adr == 3'd2) && k < 200) begin @(negedge clk); k++; end
    check_eq("reached_row2", 32'(wb_adr), 32'd2);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check_eq("mid_rst_stb", 32'(wb_stb), 32'd0);
    check_eq("mid_rst_we", 32'(wb_we), 32'd0);
    check_eq("mid_rst_adr", 32'(wb_adr), 32'd0);
    check_eq("mid_rst_dat", 32'(wb_dat_c), 32'd0);
    check_eq("mid_rst_ready", 32'(col_ready), 32'd1);
    check_eq("mid_rst_underflow", 32'(underflow), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      if (wb_stb) extra++;
    end
    check_eq("no_rows_after_rst", 32'(extra), 32'd0);
    fire_tick(tc);
    wait_drain();
    check_eq("fifo_empty_after_rst", 32'(underflow), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
